mymod_share_ctrl: RTL and testbench

//  Shares one instance of the external 16->8 "mymod" block between N requesters.

---
 rtl/mymod_share_ctrl.sv | 109 ++++++++++
 tb/tb_mymod_share_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mymod_share_ctrl.sv
// Round-robin arbiter that shares one pipelined 16->8 mymod block between N requesters.
// In-flight operations are tracked by requester id so each result returns to its issuer.
module mymod_share_ctrl #(
  parameter int unsigned N       = 4,
  parameter int unsigned EXT_LAT = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_valid,
  input  logic [16*N-1:0] req_data,
  output logic [N-1:0]    req_ready,
  input  logic            flush,
  output logic [15:0]     ext_x,
  input  logic [7:0]      ext_out,
  output logic [N-1:0]    rsp_valid,
  output logic [7:0]      rsp_data,
  output logic            idle
);

  localparam int unsigned IDW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {RUN, DRAIN} state_e;

  state_e                    state_q, state_d;
  logic [IDW-1:0]            rr_ptr_q, rr_ptr_d;
  logic [15:0]               ext_x_q, ext_x_d;
  logic [EXT_LAT:0]          tag_v_q, tag_v_d;
  logic [EXT_LAT:0][IDW-1:0] tag_id_q, tag_id_d;
  logic [N-1:0]              rsp_valid_q, rsp_valid_d;
  logic [7:0]                rsp_data_q, rsp_data_d;

  logic                      gnt_found;
  logic                      accept;
  logic [IDW-1:0]            gnt_id;
  logic [IDW-1:0]            cand;

  function automatic logic [N-1:0] onehot(input logic [IDW-1:0] id);
    logic [N-1:0] oh;
    oh = '0;
    for (int unsigned i = 0; i < N; i++) oh[i] = (id == IDW'(i));
    return oh;
  endfunction

  // Search upward from rr_ptr, wrapping; first valid requester wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    cand      = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IDW'((32'(rr_ptr_q) + k) % N);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_id    = cand;
      end
    end
  end

  always_comb begin
    accept    = gnt_found && (state_q == RUN) && !flush;
    req_ready = accept ? onehot(gnt_id) : '0;

    rr_ptr_d = rr_ptr_q;
    ext_x_d  = ext_x_q;
    if (accept) begin
      rr_ptr_d = (32'(gnt_id) == N - 1) ? '0 : gnt_id + 1'b1;
      ext_x_d  = req_data[16*gnt_id +: 16];
    end

    // Shift-in at stage 0; the cast drops the oldest stage and also covers EXT_LAT=0.
    tag_v_d  = (EXT_LAT + 1)'({tag_v_q, accept});
    tag_id_d = ((EXT_LAT + 1) * IDW)'({tag_id_q, gnt_id});

    rsp_valid_d = tag_v_q[EXT_LAT] ? onehot(tag_id_q[EXT_LAT]) : '0;
    rsp_data_d  = tag_v_q[EXT_LAT] ? ext_out : rsp_data_q;

    state_d = state_q;
    case (state_q)
      RUN:   if (flush) state_d = DRAIN;
      DRAIN: if (!flush && !(|tag_v_q)) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      rr_ptr_q    <= '0;
      ext_x_q     <= '0;
      tag_v_q     <= '0;
      tag_id_q    <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      ext_x_q     <= ext_x_d;
      tag_v_q     <= tag_v_d;
      tag_id_q    <= tag_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign ext_x     = ext_x_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign idle      = (state_q == RUN) && !(|tag_v_q) && !(|rsp_valid_q);

endmodule

// File: tb/tb_mymod_share_ctrl.sv
// Directed bench for mymod_share_ctrl: N=4/EXT_LAT=2 instance plus an EXT_LAT=0 instance,
// each fed by a mymod stub computing x[15:8]^x[7:0].
module tb_mymod_share_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rv, rr, rsv;
  logic [63:0] rd;
  logic        flush;
  logic [15:0] ex;
  logic [7:0]  eo, rsd;
  logic        idl;
  logic [7:0]  d1, d2;

  logic [3:0]  rv0, rr0, rsv0;
  logic [63:0] rd0;
  logic [15:0] ex0;
  logic [7:0]  eo0, rsd0;
  logic        idl0;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] xr [4] = '{8'h03, 8'hE0, 8'hFF, 8'h00};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    d1 <= ex[15:8] ^ ex[7:0];
    d2 <= d1;
  end
  assign eo  = d2;
  assign eo0 = ex0[15:8] ^ ex0[7:0];

  mymod_share_ctrl #(.N(4), .EXT_LAT(2)) dut (
    .clk(clk), .rst(rst), .req_valid(rv), .req_data(rd), .req_ready(rr),
    .flush(flush), .ext_x(ex), .ext_out(eo), .rsp_valid(rsv), .rsp_data(rsd), .idle(idl)
  );

  mymod_share_ctrl #(.N(4), .EXT_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(rv0), .req_data(rd0), .req_ready(rr0),
    .flush(1'b0), .ext_x(ex0), .ext_out(eo0), .rsp_valid(rsv0), .rsp_data(rsd0), .idle(idl0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; rv = '0; rv0 = '0; flush = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; rv = '0; rd = '0; flush = 1'b0; rv0 = '0; rd0 = '0;
    tick();
    #4;
    chk("rst_ext_x", ex, 0);
    chk("rst_rsp_valid", rsv, 0);
    chk("rst_rsp_data", rsd, 0);
    chk("rst_idle", idl, 1);
    tick();
    rst = 1'b0;

    // 1: single request, response four cycles later
    rv = 4'b0001; rd = 64'h0000_0000_0000_1234;
    #4; chk("t1_ready", rr, 4'b0001); tick();
    rv = '0;
    #4; chk("t1_ext_x", ex, 16'h1234); chk("t1_rsp_c1", rsv, 0); tick();
    #4; chk("t1_rsp_c2", rsv, 0); tick();
    #4; chk("t1_rsp_c3", rsv, 0); tick();
    #4; chk("t1_rsp_valid", rsv, 4'b0001); chk("t1_rsp_data", rsd, 8'h26); tick();
    #4; chk("t1_rsp_clr", rsv, 0); chk("t1_rsp_hold", rsd, 8'h26); chk("t1_idle", idl, 1); tick();

    // 2: all four valid continuously from rr_ptr=0
    do_reset();
    rd = {16'h3C3C, 16'hAA55, 16'h10F0, 16'h0102};
    for (int c = 0; c < 12; c++) begin
      rv = (c < 6) ? 4'hF : 4'h0;
      #4;
      chk("t2_ready", rr, (c < 6) ? (32'd1 << (c % 4)) : 32'd0);
      if (c >= 4 && c < 10) begin
        chk("t2_rsp_valid", rsv, 32'd1 << ((c - 4) % 4));
        chk("t2_rsp_data", rsd, xr[(c - 4) % 4]);
      end else begin
        chk("t2_rsp_idle", rsv, 0);
      end
      tick();
    end

    // 3: rr_ptr is 2 here; move it to 3, then wrap 3 -> 0 -> 1
    rv = 4'b0100;
    #4; chk("t3_ready_2", rr, 4'b0100); tick();
    rv = 4'b1001;
    #4; chk("t3_ready_3", rr, 4'b1000); tick();
    #4; chk("t3_ready_0", rr, 4'b0001); chk("t3_ext_x3", ex, 16'h3C3C); tick();
    rv = 4'b1111;
    #4; chk("t3_ptr_1", rr, 4'b0010); chk("t3_ext_x0", ex, 16'h0102); tick();
    rv = '0;
    for (int c = 0; c < 6; c++) tick();

    // 4: flush with two ops in flight
    do_reset();
    rv = 4'b0001;
    #4; chk("t4_ready_c0", rr, 4'b0001); tick();
    rv = 4'b0010;
    #4; chk("t4_ready_c1", rr, 4'b0010); tick();
    rv = 4'b1111; flush = 1'b1;
    #4; chk("t4_flush_wins", rr, 0); tick();
    flush = 1'b0;
    #4; chk("t4_drain_c3", rr, 0); chk("t4_idle_c3", idl, 0); tick();
    #4; chk("t4_drain_c4", rr, 0); chk("t4_rsp0_v", rsv, 4'b0001); chk("t4_rsp0_d", rsd, 8'h03); tick();
    #4; chk("t4_drain_c5", rr, 0); chk("t4_rsp1_v", rsv, 4'b0010); chk("t4_rsp1_d", rsd, 8'hE0);
    chk("t4_idle_c5", idl, 0); tick();
    #4; chk("t4_resume", rr, 4'b0100); chk("t4_idle_c6", idl, 1); tick();
    rv = '0;
    for (int c = 0; c < 6; c++) tick();

    // 5: async reset mid-cycle with three ops in flight
    do_reset();
    rv = 4'b1111;
    #4; chk("t5_g0", rr, 4'b0001); tick();
    #4; chk("t5_g1", rr, 4'b0010); tick();
    #4; chk("t5_g2", rr, 4'b0100); tick();
    rv = '0;
    #2; rst = 1'b1;
    #1; chk("t5_ext_x", ex, 0); chk("t5_rsp_valid", rsv, 0); chk("t5_rsp_data", rsd, 0);
    chk("t5_idle", idl, 1);
    #1; rst = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      #4; chk("t5_no_rsp", rsv, 0); tick();
    end
    rv = 4'b1111;
    #4; chk("t5_first_g0", rr, 4'b0001); tick();
    rv = '0;
    for (int c = 0; c < 6; c++) tick();

    // 6: EXT_LAT=0 instance, back-to-back accepts
    do_reset();
    rd0 = {16'h0, 16'h0, 16'h10F0, 16'h1234};
    rv0 = 4'b0001;
    #4; chk("t6_ready_0", rr0, 4'b0001); tick();
    rv0 = 4'b0010;
    #4; chk("t6_ready_1", rr0, 4'b0010); chk("t6_rsp_c1", rsv0, 0); tick();
    rv0 = '0;
    #4; chk("t6_rsp0_v", rsv0, 4'b0001); chk("t6_rsp0_d", rsd0, 8'h26); tick();
    #4; chk("t6_rsp1_v", rsv0, 4'b0010); chk("t6_rsp1_d", rsd0, 8'hE0); tick();
    #4; chk("t6_rsp_clr", rsv0, 0); chk("t6_idle", idl0, 1); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
